// File: rtl/ifft_seq.sv
// Sequential 16-point radix-2 DIF inverse FFT: bit-reversed spectrum in, natural-order time samples out.
// Optional build macro IFFT_SCALE_EN: halve every stage so the result carries the 1/16 factor.
module ifft_seq #(
    parameter int POINT_FFT_POW2 = 4,
    parameter int FRAC_BITS      = 15,
    localparam int POINT_FFT     = 1 << POINT_FFT_POW2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic signed [1:0][FRAC_BITS:0] in_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic signed [1:0][FRAC_BITS:0] out_data_o,
    output logic                           out_last_o,
    output logic                           busy_o
);
    localparam int DW = FRAC_BITS + 1;
    localparam int TW = FRAC_BITS + 2;
    localparam int PW = 2 * DW + 2;
    localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic signed [TW-1:0] tw_re(input logic [2:0] t);
        case (t)
            3'd0:    tw_re =  17'sd32768;
            3'd1:    tw_re =  17'sd30274;
            3'd2:    tw_re =  17'sd23170;
            3'd3:    tw_re =  17'sd12540;
            3'd4:    tw_re =  17'sd0;
            3'd5:    tw_re = -17'sd12540;
            3'd6:    tw_re = -17'sd23170;
            3'd7:    tw_re = -17'sd30274;
            default: tw_re =  17'sd0;
        endcase
    endfunction

    function automatic logic signed [TW-1:0] tw_im(input logic [2:0] t);
        case (t)
            3'd0:    tw_im =  17'sd0;
            3'd1:    tw_im = -17'sd12540;
            3'd2:    tw_im = -17'sd23170;
            3'd3:    tw_im = -17'sd30274;
            3'd4:    tw_im = -17'sd32768;
            3'd5:    tw_im = -17'sd30274;
            3'd6:    tw_im = -17'sd23170;
            3'd7:    tw_im = -17'sd12540;
            default: tw_im =  17'sd0;
        endcase
    endfunction

    state_t          r_state, w_state_nx;
    logic [3:0]      r_cnt, w_cnt_nx;
    logic [1:0]      r_stg, w_stg_nx;
    logic            r_in_ready, w_in_ready_nx;
    logic            r_out_valid, w_out_valid_nx;
    logic            r_out_last, w_out_last_nx;
    logic            r_busy, w_busy_nx;
    logic signed [DW-1:0] r_mem_re [POINT_FFT];
    logic signed [DW-1:0] r_mem_im [POINT_FFT];

    logic            w_in_hs, w_out_hs;
    logic [2:0]      w_bf;
    logic [3:0]      w_addr_a, w_addr_b, w_rd_addr;
    logic [2:0]      w_tw_idx;
    logic signed [DW-1:0] w_ar, w_ai, w_br, w_bi;
    logic signed [DW-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic signed [DW-1:0] w_bo_re, w_bo_im;
    logic signed [PW-1:0] w_dr_x, w_di_x, w_cr_x, w_ci_x, w_p_re, w_p_im;

    assign w_in_hs   = in_valid_i & r_in_ready;
    assign w_out_hs  = r_out_valid & out_ready_i;
    assign w_bf      = r_cnt[2:0];
    assign w_rd_addr = bitrev4(r_cnt);

    // Butterfly pair addresses and twiddle index for the current stage/butterfly
    always_comb begin
        w_addr_a = 4'd0;
        w_addr_b = 4'd0;
        w_tw_idx = 3'd0;
        case (r_stg)
            2'd0: begin
                w_addr_a = {1'b0, w_bf};
                w_addr_b = {1'b1, w_bf};
                w_tw_idx = w_bf;
            end
            2'd1: begin
                w_addr_a = {w_bf[2], 1'b0, w_bf[1:0]};
                w_addr_b = {w_bf[2], 1'b1, w_bf[1:0]};
                w_tw_idx = {w_bf[1:0], 1'b0};
            end
            2'd2: begin
                w_addr_a = {w_bf[2:1], 1'b0, w_bf[0]};
                w_addr_b = {w_bf[2:1], 1'b1, w_bf[0]};
                w_tw_idx = {w_bf[0], 2'b00};
            end
            2'd3: begin
                w_addr_a = {w_bf, 1'b0};
                w_addr_b = {w_bf, 1'b1};
                w_tw_idx = 3'd0;
            end
            default: begin
                w_addr_a = 4'd0;
                w_addr_b = 4'd0;
                w_tw_idx = 3'd0;
            end
        endcase
    end

    assign w_ar = r_mem_re[w_addr_a];
    assign w_ai = r_mem_im[w_addr_a];
    assign w_br = r_mem_re[w_addr_b];
    assign w_bi = r_mem_im[w_addr_b];

`ifdef IFFT_SCALE_EN
    // One guard bit then drop the LSB: arithmetic halving that floors
    assign w_sum_re = DW'(({w_ar[DW-1], w_ar} + {w_br[DW-1], w_br}) >> 1);
    assign w_sum_im = DW'(({w_ai[DW-1], w_ai} + {w_bi[DW-1], w_bi}) >> 1);
    assign w_dif_re = DW'(({w_ar[DW-1], w_ar} - {w_br[DW-1], w_br}) >> 1);
    assign w_dif_im = DW'(({w_ai[DW-1], w_ai} - {w_bi[DW-1], w_bi}) >> 1);
`else
    assign w_sum_re = w_ar + w_br;
    assign w_sum_im = w_ai + w_bi;
    assign w_dif_re = w_ar - w_br;
    assign w_dif_im = w_ai - w_bi;
`endif

    // Multiply the difference by conj(W): negate the stored imaginary twiddle
    assign w_dr_x = PW'(w_dif_re);
    assign w_di_x = PW'(w_dif_im);
    assign w_cr_x = PW'(tw_re(w_tw_idx));
    assign w_ci_x = -PW'(tw_im(w_tw_idx));
    assign w_p_re = (w_dr_x * w_cr_x) - (w_di_x * w_ci_x);
    assign w_p_im = (w_dr_x * w_ci_x) + (w_di_x * w_cr_x);
    assign w_bo_re = DW'((w_p_re + RND) >>> FRAC_BITS);
    assign w_bo_im = DW'((w_p_im + RND) >>> FRAC_BITS);

    // Next-state, counters and next values of the registered status outputs
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_stg_nx   = r_stg;
        case (r_state)
            ST_LOAD: begin
                if (w_in_hs) begin
                    if (r_cnt == 4'd15) begin
                        w_state_nx = ST_COMPUTE;
                        w_cnt_nx   = 4'd0;
                        w_stg_nx   = 2'd0;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt;
                end
            end
            ST_COMPUTE: begin
                if (w_bf == 3'd7) begin
                    w_cnt_nx = 4'd0;
                    if (r_stg == 2'd3) begin
                        w_state_nx = ST_UNLOAD;
                        w_stg_nx   = 2'd0;
                    end else begin
                        w_stg_nx = r_stg + 2'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 4'd1;
                end
            end
            ST_UNLOAD: begin
                if (w_out_hs) begin
                    if (r_cnt == 4'd15) begin
                        w_state_nx = ST_LOAD;
                        w_cnt_nx   = 4'd0;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt;
                end
            end
            default: begin
                w_state_nx = ST_LOAD;
                w_cnt_nx   = 4'd0;
                w_stg_nx   = 2'd0;
            end
        endcase
        w_in_ready_nx  = (w_state_nx == ST_LOAD);
        w_out_valid_nx = (w_state_nx == ST_UNLOAD);
        w_busy_nx      = (w_state_nx != ST_LOAD);
        w_out_last_nx  = (w_state_nx == ST_UNLOAD) && (w_cnt_nx == 4'd15);
    end

    // Control state and status output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_LOAD;
            r_cnt       <= 4'd0;
            r_stg       <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_stg       <= w_stg_nx;
            r_in_ready  <= w_in_ready_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_last  <= w_out_last_nx;
            r_busy      <= w_busy_nx;
        end
    end

    // Sample store: bit-reversed load, in-place butterfly write-back; never reset
    always_ff @(posedge clk_i) begin
        if ((r_state == ST_LOAD) && w_in_hs) begin
            r_mem_re[w_rd_addr] <= in_data_i[0];
            r_mem_im[w_rd_addr] <= in_data_i[1];
        end else if (r_state == ST_COMPUTE) begin
            r_mem_re[w_addr_a] <= w_sum_re;
            r_mem_im[w_addr_a] <= w_sum_im;
            r_mem_re[w_addr_b] <= w_bo_re;
            r_mem_im[w_addr_b] <= w_bo_im;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_last_o  = r_out_last;
    assign busy_o      = r_busy;
    assign out_data_o  = {r_mem_im[w_rd_addr], r_mem_re[w_rd_addr]};

endmodule
